data_sram_like_ctrl: RTL



---
 rtl/cpu_mem_pkg.sv | 24 ++
 rtl/load_extend.sv | 20 ++
 rtl/data_sram_like_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: MEM-stage access op encodings, request sizes and controller states.
package cpu_mem_pkg;
    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_e;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;
    function automatic logic is_mem_op(input mem_op_e op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    endfunction
    function automatic logic [1:0] op_size(input mem_op_e op);
        return (op == OP_LB || op == OP_LBU || op == OP_SB) ? SIZE_BYTE :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? SIZE_HALF : SIZE_WORD;
    endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/half of a raw read word and sign/zero-extends it.
module load_extend
    import cpu_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  mem_op_e     op,
    input  logic [1:0]  off,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        result = (op == OP_LB)  ? {{24{b[7]}}, b} :
                 (op == OP_LBU) ? {24'd0, b} :
                 (op == OP_LH)  ? {{16{h[15]}}, h} :
                 (op == OP_LHU) ? {16'd0, h} : rdata;
    end
endmodule

// File: rtl/data_sram_like_ctrl.sv
// data_sram_like_ctrl: MEM-stage sram-like data port controller; stalls the pipe until the
// access completes and returns extended load data.
module data_sram_like_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic [3:0]        mem_we,
    input  logic [2:0]        mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              flush,
    input  logic              pipe_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              mem_stall,
    output logic [DATA_W-1:0] load_result
);
    state_e            state_q, state_d;
    mem_op_e           op_q, op_d, op_s;
    logic [3:0]        we_q, we_d, we_s;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, wdata_s, res_q, res_d, ext;
    logic              kill_q, kill_d, start, done;

    load_extend u_ext (.rdata(data_rdata), .op(op_q), .off(addr_q[1:0]), .result(ext));

    always_comb begin
        start = (state_q == IDLE) & mem_en & ~flush & is_mem_op(mem_op_e'(mem_op));
        done = ((state_q == ADDR & data_addr_ok) | state_q == DATA) & data_data_ok;
        // The request cycle drives the live inputs; afterwards the latched copy.
        op_s = start ? mem_op_e'(mem_op) : op_q;
        we_s = start ? mem_we : we_q;
        wdata_s = start ? wdata : wdata_q;
        data_addr = start ? addr : addr_q;
        data_req = start | (state_q == ADDR);
        data_wr = |we_s;
        data_size = op_size(op_s);
        data_wdata = (op_s == OP_SB) ? {4{wdata_s[7:0]}} :
                     (op_s == OP_SH) ? {2{wdata_s[15:0]}} : wdata_s;
        mem_stall = start | (state_q == ADDR) | (state_q == DATA & ~data_data_ok);
        // Completing data is forwarded so the result is valid in the cycle stall drops.
        res_d = (done & ~kill_q & ~flush & ~|we_q) ? ext : res_q;
        load_result = res_d;
        op_d = start ? mem_op_e'(mem_op) : op_q;
        we_d = start ? mem_we : we_q;
        addr_d = start ? addr : addr_q;
        wdata_d = start ? wdata : wdata_q;
        state_d = start ? (data_addr_ok ? DATA : ADDR) :
                  done ? (pipe_stall ? DONE : IDLE) :
                  (state_q == ADDR & data_addr_ok) ? DATA :
                  (state_q == DONE & ~pipe_stall) ? IDLE : state_q;
        kill_d = (state_d == IDLE) ? 1'b0 : kill_q | (flush & (state_q == ADDR | state_q == DATA));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q <= OP_LB;
            we_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            res_q <= '0;
            kill_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            we_q <= we_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            res_q <= res_d;
            kill_q <= kill_d;
        end
    end
endmodule
